vec_stream_tx: RTL
==================

# vec_stream_tx

Vector-to-element stream transmitter that feeds the serial input port of a `layer_*` block. It accepts whole N-element input vectors over a wide valid/ready port and buffers up to DEPTH vectors. It emits them one signed T-bit element per handshake, in element order 0..N-1, on the same valid/ready stream protocol the layers consume. It sits between the vector source and a layer's `s_valid`/`s_ready`/`data_in` port, replacing the bench-side serial driver in integrated designs.

## Interface
- `N`, default 5: elements per vector.
- `T`, default 9: element width in bits, two's complement.
- `DEPTH`, default 2: vector buffer entries; a power of two and at least 2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low: `reset`==0 clears all state immediately, independent of `clk`.
- `s_valid`  in  1  input vector valid.
- `s_ready`  out  1  block can accept a vector.
- `s_data`  in  N*T  input vector; element e occupies bits [e*T +: T].
- `m_valid`  out  1  output element valid; drives the layer's `s_valid`.
- `m_ready`  in  1  layer ready; driven by the layer's `s_ready`.
- `m_data`  out  T signed  current element; drives the layer's `data_in`.
- `m_last`  out  1  current element is element N-1 of its vector.

## Operation
- Vector push: `s_valid && s_ready` on an edge writes `s_data` to buffer entry `wr_ptr`. It then increments `wr_ptr` modulo DEPTH and increments `count`.
- Element pop: `m_valid && m_ready` on an edge does one of two things.
  - When `elem`==N-1: clears `elem` to 0, increments `rd_ptr` modulo DEPTH and decrements `count`.
  - Otherwise: increments `elem`.
- Simultaneous push and final-element pop in one edge leaves `count` unchanged. Both pointers advance.
- `m_valid` = (`count` != 0).
- `m_data` = element `elem` of entry `rd_ptr` when `m_valid`, else 0.
- `m_last` = `m_valid && elem==N-1`.
- `s_ready` = `ready_en && count < DEPTH`. It is computed from registered state only, with no combinational path from `m_ready`.
  - When full, `s_ready` stays 0 even in a cycle where the final element is popped.
  - `s_ready` rises on the following cycle.
- `ready_en`: flop cleared by reset and set on the first rising edge after `reset` deasserts.
- Data stability: while `m_valid && !m_ready`, `m_data` and `m_last` hold. Writes never modify the entry at `rd_ptr` while it is occupied.
- Vectors are emitted strictly in acceptance order. No element is dropped, duplicated or reordered.

## Timing
- Reset values while `reset`==0:
  - `count`=0, `wr_ptr`=0, `rd_ptr`=0, `elem`=0, `ready_en`=0.
  - Outputs: `m_valid`=0, `m_data`=0, `m_last`=0, `s_ready`=0.
  - Buffer contents are not reset.
- `s_ready` goes to 1 one edge after reset release.
- Latency: a vector accepted at edge k presents element 0 with `m_valid`=1 in the cycle after edge k, when the buffer was empty. There is no bypass path from `s_data` to `m_data`.
- Throughput: one element per cycle under continuous `m_ready`. The N-element vector stream is gap-free while `count` stays at or above 1.
- Reset mid-vector: the partially sent vector and all buffered vectors are discarded. The first vector after reset is emitted from element 0.
- `elem` wraps from N-1 to 0. Pointers wrap from DEPTH-1 to 0.

## Structure
- Package `vec_stream_pkg`: `elem_t` (logic signed [T-1:0]) and the localparam widths `ELEM_W` = clog2(N) and `PTR_W` = clog2(DEPTH).
- Sub-module `vec_buffer`: DEPTH x (N*T) register file.
  - One write port, one read port, and the `wr_ptr`/`rd_ptr`/`count` logic.
  - Exposes `full`, `empty`, `push`, `pop` and `rd_vec`.
- Top level: holds the `elem` counter, `ready_en`, and the element select and zero-mux.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `s_valid`=1. Required: `s_ready`=0, `m_valid`=0, `m_data`=0 throughout, and `s_ready`=1 one edge after release.
- Single vector {5, -1, 100, -256, 255} with `m_ready`=1. Required: `m_data` is 5, -1, 100, -256, 255 on 5 consecutive cycles starting the cycle after acceptance, with `m_last` only on 255, then `m_valid`=0.
- Back-pressure with `m_ready`=0: push vectors A and B. Required: `s_ready`=0 after the second accept, and vector C is held off. Hold 10 cycles and check that `m_data` = A[0] is stable.
- Full plus pop of A[4] on the same edge. Required: `s_ready`=0 that cycle and 1 the next. C is then accepted and emitted after all of B.
- Reset mid-vector: after 2 elements of A are taken, pulse `reset` low asynchronously between edges. Required: `m_valid`=0 immediately, then the next pushed vector is emitted from element 0.
- Random `s_valid`/`m_ready` (50% each) over 2000 random vectors. Required: 10000 output elements in exact order, with `m_last` on every 5th, and zero mismatches.

Source files
------------

// File: rtl/vec_stream_pkg.sv
// vec_stream_pkg
// Shared types and width helpers for the vector-to-element stream
// transmitter. The *_DEFAULT values are the parameter defaults used by
// vec_stream_tx; ELEM_W and PTR_W are the matching index widths for them.
package vec_stream_pkg;

  localparam int N_DEFAULT     = 5;
  localparam int T_DEFAULT     = 9;
  localparam int DEPTH_DEFAULT = 2;

  // Width of an index able to address n items. Never less than one bit,
  // so a degenerate n of 1 still gets a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ELEM_W = idx_width(N_DEFAULT);
  localparam int PTR_W  = idx_width(DEPTH_DEFAULT);

  typedef logic signed [T_DEFAULT-1:0] elem_t;

endpackage

// File: rtl/vec_buffer.sv
// vec_buffer
// DEPTH x (N*T) circular vector buffer with one write port and one read port.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   push         write wr_vec into the entry at wr_ptr (caller ensures !full)
//   pop          release the entry at rd_ptr (caller ensures !empty)
//   wr_vec       vector to store
//   rd_vec       vector currently at rd_ptr
//   full, empty  occupancy flags
module vec_buffer
  import vec_stream_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int T     = T_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [N*T-1:0] wr_vec,
  output logic [N*T-1:0] rd_vec,
  output logic           full,
  output logic           empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [N*T-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  // Storage is deliberately not reset; occupancy is tracked by count alone.
  // push is only granted when not full, so the entry at rd_ptr is never
  // overwritten while it still holds an unsent vector.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_vec;
  end

  // Pointers wrap naturally because DEPTH is a power of two. A push and a
  // pop on the same edge cancel out in count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rd_vec = mem[rd_ptr];

endmodule

// File: rtl/vec_stream_tx.sv
// vec_stream_tx
// Accepts whole N-element vectors and emits them one signed T-bit element
// per handshake, element 0 first, in acceptance order.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   s_valid     input vector valid
//   s_ready     vector can be accepted (registered state only)
//   s_data      input vector, element e at [e*T +: T]
//   m_valid     output element valid
//   m_ready     downstream ready
//   m_data      current element, zero when m_valid is low
//   m_last      current element is element N-1 of its vector
module vec_stream_tx
  import vec_stream_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int T     = T_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N*T-1:0]      s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] m_data,
  output logic                m_last
);

  localparam int EW = idx_width(N);

  logic           ready_en;
  logic [EW-1:0]  elem;
  logic           last_elem;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [N*T-1:0] rd_vec;
  logic [T-1:0]   sel;

  // s_ready depends only on flops, so a final-element pop while full does
  // not raise it until the following cycle.
  assign s_ready   = ready_en && !full;
  assign m_valid   = !empty;
  assign last_elem = (elem == EW'(N - 1));
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready && last_elem;

  vec_buffer #(
    .N     (N),
    .T     (T),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_vec (s_data),
    .rd_vec (rd_vec),
    .full   (full),
    .empty  (empty)
  );

  // Holds s_ready low for the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Element index within the vector at rd_ptr; wraps to 0 as the
  // vector is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem <= '0;
    end else if (m_valid && m_ready) begin
      elem <= last_elem ? '0 : elem + 1'b1;
    end
  end

  // Element select from the head vector.
  always_comb begin
    sel = '0;
    for (int e = 0; e < N; e++) begin
      if (elem == EW'(e)) sel = rd_vec[e*T +: T];
    end
  end

  assign m_data = m_valid ? sel : '0;
  assign m_last = m_valid && last_elem;

endmodule
